// File: rtl/lsu_issue_arbiter.sv
// lsu_issue_arbiter
//   Round-robin issue arbiter and outstanding-request tracker for the single
//   LSU issue port of a compute unit. Grants at most one eligible wavefront per
//   cycle under a per-wavefront cap (2^WF_CNT_W-1) and a CU-wide cap
//   (MAX_TOTAL). Counts completions per wavefront and exports the memory-wait
//   vector consumed by the issue stage.
//
// Optional build macro: LSU_ARB_STATS_EN (issue / stall statistics counters).
//
// Ports:
//   clk               clock, all state on rising edge
//   rst               synchronous active-low reset (0 = reset)
//   req_valid         per-wavefront LSU instruction ready
//   lsu_ready         LSU accepts an issue this cycle
//   lsu_done          one LSU instruction retired this cycle
//   lsu_done_wfid     wavefront of the retiring instruction
//   grant_valid       issue accepted this cycle (combinational)
//   grant_wfid        granted wavefront, 0 when no grant (combinational)
//   mem_wait_arry     per-wavefront "has outstanding LSU instruction"
//   outstanding_total CU-wide in-flight count
//   err_sticky        sticky protocol error (bad/unmatched completion)
//   stat_issued       issued-instruction count (stats build, else 0)
//   stat_stall        request-pending-no-grant cycles (stats build, else 0)
module lsu_issue_arbiter #(
  parameter int unsigned NUM_WF    = 40,
  parameter int unsigned WF_CNT_W  = 3,
  parameter int unsigned MAX_TOTAL = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] req_valid,
  input  logic              lsu_ready,
  input  logic              lsu_done,
  input  logic [5:0]        lsu_done_wfid,
  output logic              grant_valid,
  output logic [5:0]        grant_wfid,
  output logic [NUM_WF-1:0] mem_wait_arry,
  output logic [5:0]        outstanding_total,
  output logic              err_sticky,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
);

  localparam int unsigned ID_W   = 6;
  localparam int unsigned TOT_W  = 6;
  localparam int unsigned STAT_W = 32;

  localparam logic [WF_CNT_W-1:0] CNT_MAX  = {WF_CNT_W{1'b1}};
  localparam logic [WF_CNT_W-1:0] CNT_ONE  = WF_CNT_W'(1);
  localparam logic [TOT_W-1:0]    TOT_CAP  = TOT_W'(MAX_TOTAL);
  localparam logic [TOT_W-1:0]    TOT_ONE  = TOT_W'(1);
  localparam logic [ID_W-1:0]     LAST_WF  = ID_W'(NUM_WF - 1);
  localparam logic [ID_W-1:0]     NUM_WF_L = ID_W'(NUM_WF);
  localparam logic [ID_W:0]       NUM_WF_X = (ID_W+1)'(NUM_WF);

  logic [WF_CNT_W-1:0] cnt_q [NUM_WF];
  logic [WF_CNT_W-1:0] cnt_d [NUM_WF];
  logic [TOT_W-1:0]    total_q, total_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;

  logic [NUM_WF-1:0]   elig;
  logic                room;
  logic                sel_found;
  logic [ID_W-1:0]     sel_idx;
  logic [ID_W:0]       pos;

  logic                done_in_range;
  logic                done_cnt_nz;
  logic                done_hits_grant;
  logic                done_valid;
  logic                done_err;
  logic [NUM_WF-1:0]   wf_inc;
  logic [NUM_WF-1:0]   wf_dec;

  // Eligibility: requesting, below per-wavefront cap, CU-wide room left
  assign room = (total_q < TOT_CAP);

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      elig[i] = req_valid[i] & (cnt_q[i] != CNT_MAX) & room;
    end
  end

  // Round-robin search: first eligible index from rr_ptr upward, wrapping
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    pos       = '0;
    for (int unsigned k = 0; k < NUM_WF; k++) begin
      pos = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (pos >= NUM_WF_X) begin
        pos = pos - NUM_WF_X;
      end
      if (!sel_found && elig[pos[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = pos[ID_W-1:0];
      end
    end
  end

  // Grant is same-cycle and suppressed while reset is held
  assign grant_valid = lsu_ready & sel_found & rst;
  assign grant_wfid  = grant_valid ? sel_idx : '0;

  // Count of the completing wavefront is nonzero (out-of-range ids read as 0)
  always_comb begin
    done_cnt_nz = 1'b0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      if (lsu_done_wfid == ID_W'(i)) begin
        done_cnt_nz = (cnt_q[i] != '0);
      end
    end
  end

  // A done to an idle wavefront is still legal if it is granted in the same cycle
  assign done_in_range   = (lsu_done_wfid < NUM_WF_L);
  assign done_hits_grant = grant_valid & (grant_wfid == lsu_done_wfid);
  assign done_valid      = lsu_done & done_in_range & (done_cnt_nz | done_hits_grant);
  assign done_err        = lsu_done & ~done_valid;

  // Per-wavefront increment/decrement strobes
  always_comb begin
    wf_inc = '0;
    wf_dec = '0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      wf_inc[i] = grant_valid & (grant_wfid == ID_W'(i));
      wf_dec[i] = done_valid & (lsu_done_wfid == ID_W'(i));
    end
  end

  // Next-state: counters, total, pointer, error flag
  always_comb begin
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wf_inc[i] && !wf_dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (wf_dec[i] && !wf_inc[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end

    total_d = total_q;
    if (grant_valid && !done_valid) begin
      total_d = total_q + TOT_ONE;
    end else if (done_valid && !grant_valid) begin
      total_d = total_q - TOT_ONE;
    end

    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (grant_wfid == LAST_WF) ? '0 : grant_wfid + ID_W'(1);
    end

    err_d = err_q | done_err;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_WF; i++) begin
        cnt_q[i] <= '0;
      end
      total_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_WF; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      total_q  <= total_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Status outputs straight from registers
  always_comb begin
    mem_wait_arry = '0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      mem_wait_arry[i] = (cnt_q[i] != '0);
    end
  end

  assign outstanding_total = total_q;
  assign err_sticky        = err_q;

`ifdef LSU_ARB_STATS_EN
  logic [STAT_W-1:0] stat_issued_q, stat_issued_d;
  logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

  // Statistics: grants issued and cycles with a request but no grant
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (grant_valid) begin
      stat_issued_d = stat_issued_q + STAT_W'(1);
    end
    if ((|req_valid) && !grant_valid) begin
      stat_stall_d = stat_stall_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_issued = STAT_W'(0);
  assign stat_stall  = STAT_W'(0);
`endif

endmodule

// File: doc/lsu_issue_arbiter.md
# lsu_issue_arbiter

Round-robin issue arbiter and outstanding-request tracker that shares the single LSU issue port among all wavefronts of a compute unit. Each cycle it grants at most one requesting wavefront, subject to a per-wavefront and a CU-wide cap on in-flight memory instructions. It counts LSU completions per wavefront and drives the per-wavefront memory-wait vector consumed by the issue stage. It sits between the issue-stage ready logic and the LSU input.

## Interface
Parameters:
- NUM_WF, 40, wavefronts per CU (equals `WF_PER_CU`)
- WF_CNT_W, 3, per-wavefront outstanding counter width; per-WF cap = 2^WF_CNT_W-1 (7)
- MAX_TOTAL, 16, CU-wide cap on in-flight LSU instructions (1..63)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- req_valid  in  NUM_WF  bit i = wavefront i has an LSU instruction ready
- lsu_ready  in  1  LSU accepts an issue this cycle
- lsu_done  in  1  one LSU instruction retired this cycle
- lsu_done_wfid  in  6  wavefront of the retiring instruction
- grant_valid  out  1  issue accepted this cycle (drives lsu_valid)
- grant_wfid  out  6  granted wavefront (drives lsu_wfid); 0 when grant_valid=0
- mem_wait_arry  out  NUM_WF  bit i = wavefront i has ≥1 outstanding LSU instruction
- outstanding_total  out  6  CU-wide in-flight count
- err_sticky  out  1  sticky protocol error flag
- stat_issued  out  32  issued-instruction count (stats build only)
- stat_stall  out  32  cycles with request pending but no grant (stats build only)

## Operation
- State: cnt[i] (WF_CNT_W bits), total (6 bits), rr_ptr (6 bits, 0..NUM_WF-1), err_sticky.
- Eligibility: elig[i] = req_valid[i] & (cnt[i] != max) & (total < MAX_TOTAL).
- Selection: the first eligible index searched from rr_ptr upward, wrapping from NUM_WF-1 to 0.
- grant_valid = lsu_ready & |elig & rst. grant_wfid is the selected index, otherwise 0.
- On grant: rr_ptr ← grant_wfid+1, wrapping NUM_WF-1 → 0. rr_ptr is unchanged without a grant.
- Counter update per wavefront i. inc = grant to i, dec = valid done for i.
  - inc & !dec: cnt+1
  - dec & !inc: cnt-1
  - both or neither: cnt unchanged
  - total follows the same rule using any grant / any valid done.
- Valid done: lsu_done & lsu_done_wfid < NUM_WF & cnt[lsu_done_wfid] != 0.
  - A done with wfid ≥ NUM_WF is ignored and sets err_sticky.
  - A done targeting a wavefront whose cnt is 0 (excluding same-cycle inc to that wavefront) is ignored and sets err_sticky.
  - Done to a wavefront with cnt=0 in the same cycle as a grant to it is valid; the net count is 0.
- mem_wait_arry[i] = (cnt[i] != 0), read from registers.
- err_sticky clears only on reset.
- Caps are never exceeded by construction: no grant is issued when either cap is reached.

## Timing
- Grant is combinational: same-cycle response from req_valid, lsu_ready and registered state.
- Counters, total and rr_ptr update at the edge ending the grant/done cycle. mem_wait_arry and outstanding_total reflect an event one cycle later.
- A completion frees capacity at the next cycle. A wavefront at cap whose done arrives in cycle N can be granted in cycle N+1 at the earliest.
- Reset (rst=0 at edge), including mid-operation:
  - all cnt, total, rr_ptr and err_sticky → 0; stats → 0
  - grant_valid is forced to 0 combinationally while rst=0
  - in-flight completions arriving after reset are counted as errors.
- Reset values: grant_valid 0, grant_wfid 0, mem_wait_arry 0, outstanding_total 0, err_sticky 0, stat_* 0.

## Configuration
- LSU_ARB_STATS_EN defined:
  - stat_issued increments on every grant.
  - stat_stall increments each cycle with |req_valid & !grant_valid & rst.
  - Both wrap at 2^32.
- LSU_ARB_STATS_EN undefined: counters are not instantiated, and stat_issued and stat_stall are tied to 0. Ports remain for a fixed interface.

## Test plan
- Reset, then req_valid bits 3 and 7 held high, lsu_ready=1, no dones -> grants 3, 7, 3, 7, ... alternating each cycle, until each reaches cnt=7 (14 grants). Then grant_valid=0, and mem_wait_arry bits 3 and 7 are set.
- MAX_TOTAL=16 with all 40 wavefronts requesting -> grants 0..15 in order. Grant stops with outstanding_total=16. One done for wf 5 -> the next cycle grants wf 16.
- Same-cycle grant to wf 2 and done for wf 2 (cnt=1) -> cnt[2] stays 1, total unchanged, mem_wait_arry[2] stays 1.
- lsu_done with wfid=45, and separately a done to idle wf 9 -> both ignored, counts unchanged, err_sticky=1 until reset.
- rst=0 asserted mid-traffic with total=10 -> next cycle all outputs are 0. req held with lsu_ready=1 during reset -> grant_valid=0. After release, the first grant is wf 0.
- Stats build: 5 cycles with a request and lsu_ready=0, then 3 grants -> stat_stall=5, stat_issued=3. Non-stats build -> both read 0.
